mvm_stream_engine: RTL

Parametrised successor to the fixed 2x4 mesh top: a signed matrix-vector multiply engine with a runtime-loadable input vector (no hard-wired X), a ROWS x COLS weight store, per-row MAC accumulators, an optional saturation mode and a valid/ready result stream. It sits between the host preload/stream interfaces and downstream result consumers. It replaces the one-shot flattened result bus with per-row beats that the consumer can back-pressure.

---
 rtl/mvm_stream_engine.sv | 105 ++++++++++
 1 files changed

// File: rtl/mvm_stream_engine.sv
// mvm_stream_engine: signed matrix-vector multiply with a loadable vector and a valid/ready per-row result stream.
module mvm_stream_engine #(
  parameter int DW       = 8,
  parameter int ROWS     = 2,
  parameter int COLS     = 4,
  parameter int ROW_W    = 1,
  parameter int COL_W    = 2,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0,
  parameter int CYCLE_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_valid,
  input  logic [ROW_W+COL_W-1:0] w_addr,
  input  logic [DW-1:0]          w_data,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [DW-1:0]          x_data,
  input  logic                   start,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       res_data,
  output logic [ROW_W-1:0]       res_row,
  output logic                   res_last,
  output logic [1:0]             global_state,
  output logic [CYCLE_W-1:0]     cycle,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, OUTPUT = 2'd2} state_t;
  state_t state, state_nx;
  logic signed [DW-1:0]    w_mem [ROWS][COLS];
  logic signed [DW-1:0]    x_buf [COLS];
  logic signed [ACC_W-1:0] acc [ROWS];
  logic signed [ACC_W-1:0] acc_nx [ROWS];
  logic [COL_W-1:0] col_ptr, x_idx, w_col;
  logic [ROW_W-1:0] out_ptr, w_row;
  logic fire, last_col, w_ok, x_fire, go;
  assign {w_row, w_col} = w_addr;
  assign w_ok = state == IDLE && w_valid && int'(w_row) < ROWS && int'(w_col) < COLS;
  assign x_fire = x_valid && x_ready;
  assign go = state == IDLE && start;
  assign last_col = int'(col_ptr) == COLS - 1;
  assign fire = res_valid && res_ready;
  assign x_ready = state == IDLE;
  assign busy = state != IDLE;
  assign global_state = state;
  assign res_valid = state == OUTPUT;
  assign res_data = acc[out_ptr];
  assign res_row = out_ptr;
  assign res_last = state == OUTPUT && int'(out_ptr) == ROWS - 1;
  // The sum carries one guard bit so overflow of a single add is always visible.
  for (genvar r = 0; r < ROWS; r++) begin : g_mac
    logic signed [2*DW-1:0] prod;
    logic signed [ACC_W:0]  sum;
    assign prod = (2*DW)'(w_mem[r][col_ptr]) * (2*DW)'(x_buf[col_ptr]);
    assign sum = (ACC_W+1)'(acc[r]) + (ACC_W+1)'(prod);
    assign acc_nx[r] = (SATURATE != 0 && sum[ACC_W] != sum[ACC_W-1]) ?
                       {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? COMPUTE : IDLE;
      COMPUTE: state_nx = last_col ? OUTPUT : COMPUTE;
      OUTPUT:  state_nx = (fire && res_last) ? IDLE : OUTPUT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cycle <= '0;
      done <= 1'b0;
      col_ptr <= '0;
      x_idx <= '0;
      out_ptr <= '0;
      for (int r = 0; r < ROWS; r++) begin
        acc[r] <= '0;
        for (int c = 0; c < COLS; c++) w_mem[r][c] <= '0;
      end
      for (int c = 0; c < COLS; c++) x_buf[c] <= '0;
    end else begin
      state <= state_nx;
      cycle <= (state_nx != state) ? '0 : (&cycle ? cycle : cycle + 1'b1);
      done <= fire && res_last;
      if (w_ok) w_mem[w_row][w_col] <= w_data;
      if (x_fire) x_buf[x_idx] <= x_data;
      if (go) begin
        x_idx <= '0;
        col_ptr <= '0;
        for (int r = 0; r < ROWS; r++) acc[r] <= '0;
      end else if (x_fire) begin
        x_idx <= (int'(x_idx) == COLS - 1) ? '0 : x_idx + 1'b1;
      end
      if (state == COMPUTE) begin
        acc <= acc_nx;
        col_ptr <= col_ptr + 1'b1;
      end
      if (state == COMPUTE && last_col) out_ptr <= '0;
      else if (fire && !res_last) out_ptr <= out_ptr + 1'b1;
    end
  end
endmodule
